// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches words over a req/ack handshake,
// holds them in the instruction register for the decoder and resolves the next PC.
module instruction_fetch_unit #(
    parameter int unsigned       PC_W     = 8,
    parameter int unsigned       INSTR_W  = 17,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] Instruction_out,
    output logic               instr_valid,
    input  logic               stall,
    input  logic [1:0]         BS,
    input  logic               PS,
    input  logic               Z,
    input  logic [PC_W-1:0]    branch_off,
    input  logic [PC_W-1:0]    RAA,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W-1:0]    PC_plus1
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        ISSUE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_rel;
    logic               cond_taken;

    // Modulo-2^PC_W adders; a two's-complement offset wraps the same way as an unsigned add.
    assign pc_inc     = pc_q + PC_W'(1);
    assign pc_rel     = pc_q + branch_off;
    assign cond_taken = Z ^ PS;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        unique case (state_q)
            RST_WAIT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Branch controls are only meaningful on the cycle the stall releases.
                if (!stall) begin
                    state_d = FETCH;
                    unique case (BS)
                        2'b00: pc_d = pc_inc;
                        2'b01: pc_d = cond_taken ? pc_rel : pc_inc;
                        2'b10: pc_d = pc_rel;
                        2'b11: pc_d = RAA;
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            default: begin
                state_d = RST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= RST_WAIT;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_req        = (state_q == FETCH);
    assign instr_valid     = (state_q == ISSUE);
    assign imem_addr       = pc_q;
    assign PC              = pc_q;
    assign PC_plus1        = pc_inc;
    assign Instruction_out = ir_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed fetch/issue vectors push expected
// issue transactions; a negedge monitor pops and compares each committed instruction.
module tb_instruction_fetch_unit;

    localparam logic [7:0] RESET_PC = 8'h00;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [16:0] imem_rdata;
    logic [16:0] Instruction_out;
    logic        instr_valid;
    logic        stall;
    logic [1:0]  BS;
    logic        PS;
    logic        Z;
    logic [7:0]  branch_off;
    logic [7:0]  RAA;
    logic [7:0]  PC;
    logic [7:0]  PC_plus1;

    instruction_fetch_unit #(
        .PC_W     (8),
        .INSTR_W  (17),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .Instruction_out (Instruction_out),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .BS              (BS),
        .PS              (PS),
        .Z               (Z),
        .branch_off      (branch_off),
        .RAA             (RAA),
        .PC              (PC),
        .PC_plus1        (PC_plus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [16:0] ir;
        logic [7:0]  pc1;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [7:0]  model_pc;
    logic [16:0] cur_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every committing ISSUE cycle must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && instr_valid && !stall) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sb_underflow: unexpected issue at PC 0x%0h, expected none", PC);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("issue_pc",       32'(PC),              32'(e.pc));
                check("issue_ir",       32'(Instruction_out), 32'(e.ir));
                check("issue_pc_plus1", 32'(PC_plus1),        32'(e.pc1));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},   32'(imem_req),        32'(0));
        check({tag, "_valid"}, 32'(instr_valid),     32'(0));
        check({tag, "_pc"},    32'(PC),              32'(RESET_PC));
        check({tag, "_addr"},  32'(imem_addr),       32'(RESET_PC));
        check({tag, "_ir"},    32'(Instruction_out), 32'(0));
        check({tag, "_pc1"},   32'(PC_plus1),        32'(RESET_PC + 8'd1));
    endtask

    // Called in the first FETCH cycle; returns in the ISSUE cycle.
    task automatic fetch(input int waits, input logic [16:0] word);
        for (int i = 0; i <= waits; i++) begin
            check("fetch_req",   32'(imem_req),    32'(1));
            check("fetch_addr",  32'(imem_addr),   32'(model_pc));
            check("fetch_pc",    32'(PC),          32'(model_pc));
            check("fetch_valid", 32'(instr_valid), 32'(0));
            imem_ack   = (i == waits);
            imem_rdata = (i == waits) ? word : (17'h1_0F0F ^ 17'(i));
            step();
        end
        imem_ack   = 1'b0;
        imem_rdata = 17'h0_DEAD;
        cur_word   = word;
    endtask

    // Called in the first ISSUE cycle; stall cycles present inverted controls that must be ignored.
    task automatic issue(input logic [1:0] bs, input logic ps, input logic z,
                         input logic [7:0] off, input logic [7:0] raa,
                         input int stalls, input logic [7:0] exp_next);
        check("issue_valid_hi", 32'(instr_valid), 32'(1));
        check("issue_req_lo",   32'(imem_req),    32'(0));
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1; BS = ~bs; PS = ~ps; Z = ~z; branch_off = ~off; RAA = ~raa;
            step();
            check("stall_pc",    32'(PC),              32'(model_pc));
            check("stall_valid", 32'(instr_valid),     32'(1));
            check("stall_ir",    32'(Instruction_out), 32'(cur_word));
        end
        stall = 1'b0; BS = bs; PS = ps; Z = z; branch_off = off; RAA = raa;
        sb_q.push_back('{model_pc, cur_word, model_pc + 8'd1});
        step();
        model_pc = exp_next;
        BS = 2'b00; PS = 1'b0; Z = 1'b0; branch_off = 8'h00; RAA = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    logic [7:0] cond_exp [4];
    logic [1:0] kk;

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
        BS = 2'b00; PS = 1'b0; Z = 1'b0; branch_off = '0; RAA = '0;
        model_pc = RESET_PC; cur_word = '0;
        // index {PS,Z}: taken when Z^PS=1 -> 0x10+0xFC=0x0C, else 0x11
        cond_exp = '{8'h11, 8'h0C, 8'h0C, 8'h11};

        // Reset for 2 cycles, then RST_WAIT, then FETCH.
        step(); step();
        check_reset_state("reset");
        rst = 1'b0;
        check("rst_wait_req", 32'(imem_req), 32'(0));
        step();

        // Sequential fetch with zero-wait memory.
        fetch(0, 17'h0_1111); issue(2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h01);
        fetch(0, 17'h1_2222); issue(2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h02);
        fetch(0, 17'h0_3333); issue(2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h03);
        fetch(0, 17'h1_4444); issue(2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h04);

        // Wait states at 0xFF and wrap to 0x00.
        fetch(0, 17'h0_A0A0); issue(2'b11, 0, 0, 8'h00, 8'hFF, 0, 8'hFF);
        fetch(3, 17'h1_5A5A); issue(2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00);

        // Conditional branch truth table at PC=0x10, offset -4.
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            fetch(0, 17'h0_B000 | 17'(k)); issue(2'b11, 0, 0, 8'h00, 8'h10, 0, 8'h10);
            fetch(0, 17'h0_C000 | 17'(k)); issue(2'b01, kk[1], kk[0], 8'hFC, 8'h00, 0, cond_exp[k]);
        end

        // Jump deferred by two stall cycles.
        fetch(0, 17'h0_D00D); issue(2'b11, 0, 0, 8'h00, 8'h5A, 2, 8'h5A);

        // Unconditional relative branch 0x7F + 1.
        fetch(0, 17'h1_7F7F); issue(2'b11, 0, 0, 8'h00, 8'h7F, 0, 8'h7F);
        fetch(0, 17'h0_0707); issue(2'b10, 0, 0, 8'h01, 8'h00, 0, 8'h80);

        // Stray ack during a stalled ISSUE.
        fetch(0, 17'h1_E0E0);
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 17'h0_0BAD;
        step();
        imem_ack = 1'b0;
        check("stray_issue_ir",    32'(Instruction_out), 32'(17'h1_E0E0));
        check("stray_issue_valid", 32'(instr_valid),     32'(1));
        check("stray_issue_pc",    32'(PC),              32'(8'h80));
        issue(2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h81);

        // Reset in ISSUE with a pending jump.
        fetch(0, 17'h0_F00F);
        BS = 2'b11; RAA = 8'h77; rst = 1'b1;
        step();
        check_reset_state("rst_issue");
        model_pc = RESET_PC;

        // Stray ack in RST_WAIT: normal move to FETCH, IR untouched.
        rst = 1'b0; BS = 2'b00; RAA = 8'h00; imem_ack = 1'b1; imem_rdata = 17'h1_BEEF;
        step();
        imem_ack = 1'b0;
        check("stray_rw_ir",    32'(Instruction_out), 32'(0));
        check("stray_rw_req",   32'(imem_req),        32'(1));
        check("stray_rw_valid", 32'(instr_valid),     32'(0));

        // Reset in FETCH together with an ack.
        imem_ack = 1'b1; imem_rdata = 17'h1_CAFE; rst = 1'b1;
        step();
        check_reset_state("rst_fetch");
        rst = 1'b0; imem_ack = 1'b0;
        step();
        fetch(0, 17'h0_1234); issue(2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h01);
        check("final_pc", 32'(PC), 32'(8'h01));

        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
